// File: rtl/vit_pkg.sv
// Shared types for the ViT layer sequencer: FSM state encoding and the
// layer-select width helper.
package vit_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_WT,
    START_ENC,
    WAIT_ENC,
    FINISH
  } seq_state_t;

  // Width of a layer index; a single-layer build still gets a 1-bit select.
  function automatic int layer_w(input int num_layers);
    return (num_layers > 1) ? $clog2(num_layers) : 1;
  endfunction

endpackage

// File: rtl/vit_seq_watchdog.sv
// Stall counter for the layer sequencer: counts cycles spent waiting on the
// weight bank or encoder and flags a timeout at TIMEOUT_CYCLES-1.
module vit_seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic count_en,
  input  logic restart,
  output logic timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!count_en || restart) begin
      cnt_q <= '0;
    end else if (cnt_q != LIMIT) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign timeout = count_en && (cnt_q == LIMIT);

endmodule

// File: rtl/vit_layer_sequencer.sv
// Runs one shared encoder block through NUM_LAYERS layers, feeding each result
// back as the next input. Optional stall watchdog: define VIT_SEQ_WATCHDOG_EN.
module vit_layer_sequencer
  import vit_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int SEQ_LEN        = 8,
  parameter int EMB_DIM        = 8,
  parameter int NUM_LAYERS     = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int NUM_ELEM      = SEQ_LEN * EMB_DIM,
  localparam int LAYER_W       = layer_w(NUM_LAYERS)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                abort,
  input  logic [NUM_ELEM-1:0][DATA_WIDTH-1:0] x_in,
  output logic [LAYER_W-1:0]                  layer_idx,
  output logic                                wt_req,
  input  logic                                wt_ready,
  output logic                                enc_start,
  input  logic                                enc_done,
  output logic [NUM_ELEM-1:0][DATA_WIDTH-1:0] enc_x,
  input  logic [NUM_ELEM-1:0][DATA_WIDTH-1:0] enc_y,
  output logic [NUM_ELEM-1:0][DATA_WIDTH-1:0] y_out,
  output logic                                busy,
  output logic                                done,
  output logic                                err
);

  seq_state_t                          state_q, state_d;
  logic [LAYER_W-1:0]                  layer_q;
  logic [NUM_ELEM-1:0][DATA_WIDTH-1:0] fb_q;
  logic [NUM_ELEM-1:0][DATA_WIDTH-1:0] y_q;
  logic                                last_layer;
  logic                                abort_req;
  logic                                wd_timeout;
  logic                                wd_fire;

  assign last_layer = (layer_q == LAYER_W'(NUM_LAYERS - 1));
  assign abort_req  = abort && (state_q != IDLE);

  // A timeout only counts when nothing else moved the FSM this cycle.
  assign wd_fire = wd_timeout && !abort_req &&
                   ((state_q == LOAD_WT  && !wt_ready) ||
                    (state_q == WAIT_ENC && !enc_done));

  always_comb begin
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (start) state_d = LOAD_WT;
      LOAD_WT:   if (wt_ready) state_d = START_ENC;
                 else if (wd_fire) state_d = IDLE;
      START_ENC: state_d = WAIT_ENC;
      WAIT_ENC:  if (enc_done) state_d = last_layer ? FINISH : LOAD_WT;
                 else if (wd_fire) state_d = IDLE;
      FINISH:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (abort_req) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    // NOTE: the activation buffer is plain flops rather than a RAM, so it can
    // take a reset and enc_x is defined (all zero) straight out of reset.
    if (!rst_n) begin
      state_q <= IDLE;
      layer_q <= '0;
      fb_q    <= '0;
      y_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        fb_q    <= x_in;
        layer_q <= '0;
      end else if (state_q == WAIT_ENC && enc_done && !abort) begin
        fb_q <= enc_y;
        if (last_layer) y_q <= enc_y;
        else            layer_q <= layer_q + LAYER_W'(1);
      end
    end
  end

`ifdef VIT_SEQ_WATCHDOG_EN
  logic err_q;

  vit_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .count_en (state_q == LOAD_WT || state_q == WAIT_ENC),
    .restart  (state_d != state_q),
    .timeout  (wd_timeout)
  );

  // Sticky until the next accepted start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      err_q <= 1'b0;
    end else if (wd_fire) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign wd_timeout = 1'b0;
  assign err        = 1'b0;
`endif

  assign layer_idx = layer_q;
  assign wt_req    = (state_q == LOAD_WT);
  assign enc_start = (state_q == START_ENC);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);
  assign enc_x     = fb_q;
  assign y_out     = y_q;

endmodule
